// File: rtl/mitll_jtl_pkg.sv
// -----------------------------------------------------------------------------
// mitll_jtl_pkg
// Shared constants, types and helpers for the clocked multi-lane JTL timing
// model (mitll_jtl_array / mitll_jtl_lane).
//   DEF_*   : default parameter values (one tick = 100 fs)
//   tick_t  : tick counter wide enough for any of the default tick constants
//   sat_add : saturating unsigned add used by the global violation counter
// -----------------------------------------------------------------------------
package mitll_jtl_pkg;

  localparam int DEF_NCH     = 4;
  localparam int DEF_DELAY   = 37;  // 3.7 ps
  localparam int DEF_CT      = 33;  // 3.3 ps
  localparam int DEF_STARTUP = 40;
  localparam int DEF_CW      = 16;

  localparam int TICK_MAX_DC = (DEF_DELAY > DEF_CT) ? DEF_DELAY : DEF_CT;
  localparam int TICK_MAX    = (TICK_MAX_DC > DEF_STARTUP) ? TICK_MAX_DC : DEF_STARTUP;
  localparam int TICK_W      = $clog2(TICK_MAX + 1);

  typedef logic [TICK_W-1:0] tick_t;

  // Unsigned a+b clamped to max_v; the 33-bit sum keeps the carry so that a
  // wrap of the 32-bit result can never sneak under the limit.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_v}) begin
      sat_add = max_v;
    end else begin
      sat_add = sum[31:0];
    end
  endfunction

endpackage

// File: rtl/mitll_jtl_lane.sv
// -----------------------------------------------------------------------------
// mitll_jtl_lane
// One JTL lane: edge detect on a toggle-encoded input, critical-timing window
// check, DELAY-deep pulse shift line and per-lane status flags.
// Ports:
//   clk     in  1  timing-quantum clock
//   rst     in  1  synchronous active-high reset
//   run_en  in  1  0 while the array is in its startup period (edges ignored)
//   clr_err in  1  clears the sticky out_x flag
//   in_lvl  in  1  toggle-encoded input, every level change is one pulse
//   out_lvl out 1  toggle-encoded output, DELAY ticks after an accepted pulse
//   out_x   out 1  sticky "output unknown" flag
//   err_pls out 1  one-tick violation strobe
//   viol    out 1  violation seen on the previous edge (feeds global counter)
// -----------------------------------------------------------------------------
module mitll_jtl_lane
  import mitll_jtl_pkg::*;
#(
  parameter int DELAY = DEF_DELAY,
  parameter int CT    = DEF_CT
) (
  input  logic clk,
  input  logic rst,
  input  logic run_en,
  input  logic clr_err,
  input  logic in_lvl,
  output logic out_lvl,
  output logic out_x,
  output logic err_pls,
  output logic viol
);

  // The window counter only ever needs to hold CT-1; an accepted pulse loads
  // it and the following CT-1 edges see it non-zero.
  localparam int              CT_W    = (CT > 1) ? $clog2(CT) : 1;
  localparam logic [CT_W-1:0] CT_LOAD = CT_W'((CT > 0) ? (CT - 1) : 0);
  localparam logic [CT_W-1:0] CT_ONE  = CT_W'(1);
  localparam logic [CT_W-1:0] CT_ZERO = {CT_W{1'b0}};

  logic             in_q_r;
  logic [CT_W-1:0]  ct_cnt_r;
  logic [DELAY-1:0] line_r;
  logic [DELAY-1:0] line_nxt_s;
  logic             viol_r;
  logic             out_lvl_r;
  logic             out_x_r;
  logic             err_pls_r;
  logic             edge_s;
  logic             acc_s;
  logic             viol_s;

  // Classify the current edge as accepted, violation or ignored.
  always_comb begin
    edge_s = in_lvl ^ in_q_r;
    acc_s  = 1'b0;
    viol_s = 1'b0;
    if (!run_en) begin
      acc_s  = 1'b0;
      viol_s = 1'b0;
    end else if (!edge_s) begin
      acc_s  = 1'b0;
      viol_s = 1'b0;
    end else if (ct_cnt_r != CT_ZERO) begin
      acc_s  = 1'b0;
      viol_s = 1'b1;
    end else begin
      acc_s  = 1'b1;
      viol_s = 1'b0;
    end
  end

  // Next state of the shift line: new pulse enters at bit 0.
  always_comb begin
    line_nxt_s    = line_r;
    line_nxt_s[0] = acc_s;
    for (int j = 1; j < DELAY; j++) begin
      line_nxt_s[j] = line_r[j-1];
    end
  end

  // Lane state. A violation detected on edge k is latched into viol_r and
  // published (err_pls, out_x, global count) on edge k+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q_r    <= in_lvl;
      ct_cnt_r  <= CT_ZERO;
      line_r    <= {DELAY{1'b0}};
      viol_r    <= 1'b0;
      out_lvl_r <= 1'b0;
      out_x_r   <= 1'b0;
      err_pls_r <= 1'b0;
    end else begin
      in_q_r <= in_lvl;
      if (acc_s) begin
        ct_cnt_r <= CT_LOAD;
      end else if (ct_cnt_r != CT_ZERO) begin
        ct_cnt_r <= ct_cnt_r - CT_ONE;
      end else begin
        ct_cnt_r <= ct_cnt_r;
      end
      line_r    <= line_nxt_s;
      viol_r    <= viol_s;
      err_pls_r <= viol_r;
      out_lvl_r <= out_lvl_r ^ line_r[DELAY-1];
      // Clear first, then set: a violation in the clearing tick survives.
      out_x_r   <= (out_x_r & ~clr_err) | viol_r;
    end
  end

  assign out_lvl = out_lvl_r;
  assign out_x   = out_x_r;
  assign err_pls = err_pls_r;
  assign viol    = viol_r;

endmodule

// File: rtl/mitll_jtl_array.sv
// -----------------------------------------------------------------------------
// mitll_jtl_array
// NCH independent JTL timing lanes sharing a startup mask and a global
// saturating violation counter.
// Ports:
//   clk     in  1    timing-quantum clock (100 fs per tick)
//   rst     in  1    synchronous active-high reset
//   in_lvl  in  NCH  toggle-encoded pulse inputs
//   clr_err in  1    clears out_x and err_cnt
//   out_lvl out NCH  toggle-encoded pulse outputs
//   out_x   out NCH  sticky per-lane "output unknown" flags
//   err_pls out NCH  one-tick per-lane violation strobes
//   err_cnt out CW   saturating count of all violations (CW <= 31)
// -----------------------------------------------------------------------------
module mitll_jtl_array
  import mitll_jtl_pkg::*;
#(
  parameter int NCH     = DEF_NCH,
  parameter int DELAY   = DEF_DELAY,
  parameter int CT      = DEF_CT,
  parameter int STARTUP = DEF_STARTUP,
  parameter int CW      = DEF_CW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] in_lvl,
  input  logic           clr_err,
  output logic [NCH-1:0] out_lvl,
  output logic [NCH-1:0] out_x,
  output logic [NCH-1:0] err_pls,
  output logic [CW-1:0]  err_cnt
);

  localparam int              SU_W    = (STARTUP > 0) ? $clog2(STARTUP + 1) : 1;
  localparam logic [SU_W-1:0] SU_LOAD = SU_W'(STARTUP);
  localparam logic [SU_W-1:0] SU_ONE  = SU_W'(1);
  localparam logic [SU_W-1:0] SU_ZERO = {SU_W{1'b0}};
  localparam int              PC_W    = $clog2(NCH + 1);
  localparam logic [31:0]     CNT_MAX = (32'd1 << CW) - 32'd1;

  logic [SU_W-1:0] su_cnt_r;
  logic            run_en_s;
  logic [NCH-1:0]  viol_vec_s;
  logic [PC_W-1:0] viol_num_s;
  logic [31:0]     cnt_base_s;
  logic [31:0]     cnt_sum_s;
  logic [CW-1:0]   err_cnt_r;

  // Startup mask: edges are ignored until the counter has run down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      su_cnt_r <= SU_LOAD;
    end else if (su_cnt_r != SU_ZERO) begin
      su_cnt_r <= su_cnt_r - SU_ONE;
    end else begin
      su_cnt_r <= su_cnt_r;
    end
  end

  assign run_en_s = (su_cnt_r == SU_ZERO);

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    mitll_jtl_lane #(
      .DELAY (DELAY),
      .CT    (CT)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .run_en  (run_en_s),
      .clr_err (clr_err),
      .in_lvl  (in_lvl[i]),
      .out_lvl (out_lvl[i]),
      .out_x   (out_x[i]),
      .err_pls (err_pls[i]),
      .viol    (viol_vec_s[i])
    );
  end

  // Popcount of this tick's violations and the saturated counter update;
  // clr_err zeroes the base before the new violations are added.
  always_comb begin
    viol_num_s = {PC_W{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      viol_num_s = viol_num_s + PC_W'(viol_vec_s[i]);
    end
    if (clr_err) begin
      cnt_base_s = 32'd0;
    end else begin
      cnt_base_s = 32'(err_cnt_r);
    end
    cnt_sum_s = sat_add(cnt_base_s, 32'(viol_num_s), CNT_MAX);
  end

  // Global violation counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_r <= {CW{1'b0}};
    end else begin
      err_cnt_r <= cnt_sum_s[CW-1:0];
    end
  end

  assign err_cnt = err_cnt_r;

endmodule
